// File: rtl/rst_mp_pkg.sv
// Shared defaults and entry layout for the register status table (rst_mp).
// The table is stored as separate valid/tag arrays; VALID_BIT and TAG_LSB
// describe the {valid, tag} entry packing used at the match boundary.
package rst_mp_pkg;
    localparam int DEF_TAG_W    = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_CDB  = 2;
    localparam int TAG_LSB      = 0;

    // Valid flag sits directly above the tag field.
    function automatic int valid_bit(input int tag_w);
        return tag_w;
    endfunction
endpackage

// File: rtl/rst_cdb_match.sv
// One table entry compared against every CDB channel.
// Invalid entries never hit; duplicate tags across channels collapse to one hit.
module rst_cdb_match
    import rst_mp_pkg::*;
#(
    parameter int TAG_W   = DEF_TAG_W,
    parameter int NUM_CDB = DEF_NUM_CDB
) (
    input  logic [TAG_W:0]               entry,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag,
    output logic                         hit
);
    localparam int VALID_BIT = TAG_W;

    // OR of per-channel tag matches, qualified by the entry valid flag
    always_comb begin
        hit = 1'b0;
        for (int c = 0; c < NUM_CDB; c++)
            if (cdb_valid[c] && entry[TAG_LSB +: TAG_W] == cdb_tag[c])
                hit = 1'b1;
        hit = hit & entry[VALID_BIT];
    end
endmodule

// File: rtl/rst_mp.sv
// Register status table for Tomasulo dispatch: one {valid, tag} per register,
// NR_RD combinational read ports, one rename write per cycle, NUM_CDB clears.
// Priority per edge: flush > rename write > CDB clear.
// Optional feature macro: RST_CDB_BYPASS_EN -- a read whose entry hits the CDB
// in the same cycle returns {0,0}.
module rst_mp
    import rst_mp_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int NR_RD     = 2,
    parameter int NUM_CDB   = DEF_NUM_CDB,
    parameter int ZERO_HARD = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NR_RD*ADDR_W-1:0]  rd_addr,
    output logic [NR_RD*TAG_W-1:0]   rd_tag,
    output logic [NR_RD-1:0]         rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    output logic [NUM_REGS-1:0]      cdb_hit,
    output logic [CNT_W-1:0]         busy_cnt
);
    logic [NUM_REGS-1:0]             ent_v, nxt_v;
    logic [NUM_REGS-1:0][TAG_W-1:0]  ent_tag, nxt_tag;
    logic [NUM_CDB-1:0][TAG_W-1:0]   cdb_tag_a;
    logic [CNT_W-1:0]                nxt_cnt;
    logic                            wr_ok;

    assign cdb_tag_a = cdb_tag;

    // Per-entry CDB comparators
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_match
            rst_cdb_match #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_match (
                .entry     ({ent_v[gi], ent_tag[gi]}),
                .cdb_valid (cdb_valid),
                .cdb_tag   (cdb_tag_a),
                .hit       (cdb_hit[gi])
            );
        end
    endgenerate

    // Register 0 is hardwired invalid when ZERO_HARD is set, so its write is dropped
    assign wr_ok = wr_en && !(ZERO_HARD != 0 && wr_addr == '0);

    // Next table state: clears first, then the rename write overrides its entry
    always_comb begin
        nxt_v   = ent_v;
        nxt_tag = ent_tag;
        if (flush) begin
            nxt_v   = '0;
            nxt_tag = '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (cdb_hit[i]) begin
                    nxt_v[i]   = 1'b0;
                    nxt_tag[i] = '0;
                end
            if (wr_ok) begin
                nxt_v[wr_addr]   = 1'b1;
                nxt_tag[wr_addr] = wr_tag;
            end
        end
    end

    // Popcount of the next state keeps busy_cnt exact under write + clears
    always_comb begin
        nxt_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            nxt_cnt = nxt_cnt + CNT_W'(nxt_v[i]);
    end

    // Table and count registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_v    <= '0;
            ent_tag  <= '0;
            busy_cnt <= '0;
        end else begin
            ent_v    <= nxt_v;
            ent_tag  <= nxt_tag;
            busy_cnt <= nxt_cnt;
        end
    end

    // Read ports: raw table state, optionally masked by a same-cycle CDB hit
    always_comb begin
        rd_valid = '0;
        rd_tag   = '0;
        for (int p = 0; p < NR_RD; p++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[p*ADDR_W +: ADDR_W];
            rd_valid[p]               = ent_v[a];
            rd_tag[p*TAG_W +: TAG_W]  = ent_tag[a];
`ifdef RST_CDB_BYPASS_EN
            if (cdb_hit[a]) begin
                rd_valid[p]              = 1'b0;
                rd_tag[p*TAG_W +: TAG_W] = '0;
            end
`endif
            if (ZERO_HARD != 0 && a == '0) begin
                rd_valid[p]              = 1'b0;
                rd_tag[p*TAG_W +: TAG_W] = '0;
            end
        end
    end
endmodule

// File: tb/tb_rst_mp.sv
// Directed bench for rst_mp (default parameters). Expected values hand-computed.
module tb_rst_mp;
    logic        clock = 1'b0;
    logic        reset, flush, wr_en;
    logic [9:0]  rd_addr;
    logic [9:0]  rd_tag;
    logic [1:0]  rd_valid;
    logic [4:0]  wr_addr, wr_tag;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_tag;
    logic [31:0] cdb_hit;
    logic [5:0]  busy_cnt;
    int total = 0, bad = 0;

    rst_mp dut (
        .clock(clock), .reset(reset), .flush(flush),
        .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_tag(wr_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_hit(cdb_hit), .busy_cnt(busy_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change 1ns after posedge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [4:0] t);
        wr_en = 1; wr_addr = a; wr_tag = t;
        step();
        wr_en = 0;
    endtask

    // port 0 read: {valid, tag}
    task automatic rd0(input string tag, input logic [4:0] a, input logic [5:0] exp);
        rd_addr[4:0] = a;
        #1;
        chk(tag, {26'd0, rd_valid[0], rd_tag[4:0]}, {26'd0, exp});
    endtask

    task automatic rd1(input string tag, input logic [4:0] a, input logic [5:0] exp);
        rd_addr[9:5] = a;
        #1;
        chk(tag, {26'd0, rd_valid[1], rd_tag[9:5]}, {26'd0, exp});
    endtask

    initial begin
        reset = 1; flush = 0; wr_en = 0; wr_addr = 0; wr_tag = 0;
        rd_addr = 0; cdb_valid = 0; cdb_tag = 0;
        #12;
        chk("reset_busy", {26'd0, busy_cnt}, 0);
        reset = 0;
        step();
        // 1: every address reads {0,0}
        for (int a = 0; a < 32; a++) rd0("reset_rd", 5'(a), 6'h00);
        chk("reset_hit", cdb_hit, 0);

        // 2: write visible next cycle, not forwarded same cycle
        wr_en = 1; wr_addr = 5; wr_tag = 9; rd_addr[4:0] = 5;
        #1;
        chk("no_fwd", {31'd0, rd_valid[0]}, 0);
        step(); wr_en = 0;
        rd0("r5_t9", 5, {1'b1, 5'd9});
        chk("busy_1", {26'd0, busy_cnt}, 1);

        // 3: multi-clear across two channels
        wr(3, 4); wr(7, 4); wr(8, 6);
        chk("busy_4", {26'd0, busy_cnt}, 4);
        cdb_valid = 2'b11; cdb_tag = {5'd6, 5'd4};
        #1;
        chk("hit_378", cdb_hit, 32'h0000_0188);
`ifdef RST_CDB_BYPASS_EN
        rd0("bypass_r3", 3, 6'h00);
`else
        rd0("raw_r3", 3, {1'b1, 5'd4});
`endif
        step(); cdb_valid = 0;
        rd0("r3_clr", 3, 6'h00);
        rd1("r8_clr", 8, 6'h00);
        chk("busy_after_clr", {26'd0, busy_cnt}, 1);

        // duplicate tag on both channels acts as one hit
        cdb_valid = 2'b11; cdb_tag = {5'd9, 5'd9};
        #1;
        chk("dup_hit", cdb_hit, 32'h0000_0020);
        step(); cdb_valid = 0;
        chk("dup_busy", {26'd0, busy_cnt}, 0);

        // 4: write beats clear on the same entry
        wr(2, 1);
        chk("busy_r2", {26'd0, busy_cnt}, 1);
        wr_en = 1; wr_addr = 2; wr_tag = 12; cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd1};
        step(); wr_en = 0; cdb_valid = 0;
        rd1("r2_t12", 2, {1'b1, 5'd12});
        chk("busy_keep", {26'd0, busy_cnt}, 1);

        // invalid entries with tag 0 never hit
        cdb_valid = 2'b01; cdb_tag = 0;
        #1;
        chk("no_hit_inv", cdb_hit, 0);
        cdb_valid = 0;

        // simultaneous write of one entry and clear of another; rewrite keeps count
        wr(1, 5);
        wr_en = 1; wr_addr = 9; wr_tag = 8; cdb_valid = 2'b10; cdb_tag = {5'd5, 5'd0};
        step(); wr_en = 0; cdb_valid = 0;
        chk("wr_clr_cnt", {26'd0, busy_cnt}, 2);
        wr(9, 10);
        chk("rewrite_cnt", {26'd0, busy_cnt}, 2);
        rd0("r9_t10", 9, {1'b1, 5'd10});

        // 5: fill 10 entries, flush with a write pending
        for (int a = 10; a < 20; a++) wr(5'(a), 5'(a));
        chk("busy_12", {26'd0, busy_cnt}, 12);
        flush = 1; wr_en = 1; wr_addr = 4; wr_tag = 7; cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd12};
        step(); flush = 0; wr_en = 0; cdb_valid = 0;
        chk("flush_busy", {26'd0, busy_cnt}, 0);
        rd0("flush_r4", 4, 6'h00);
        rd1("flush_r15", 15, 6'h00);

        // 6: register 0 is hardwired invalid
        wr(0, 3);
        rd0("r0_inv", 0, 6'h00);
        chk("r0_busy", {26'd0, busy_cnt}, 0);

        // same-cycle read of a hitting entry
        wr(6, 2);
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd2};
`ifdef RST_CDB_BYPASS_EN
        rd0("bypass_r6", 6, 6'h00);
`else
        rd0("raw_r6", 6, {1'b1, 5'd2});
`endif
        step(); cdb_valid = 0;
        rd0("r6_clr", 6, 6'h00);

        // async reset mid-write wins immediately
        wr(11, 3);
        wr_en = 1; wr_addr = 12; wr_tag = 4;
        #2 reset = 1;
        #1;
        chk("async_busy", {26'd0, busy_cnt}, 0);
        rd0("async_r11", 11, 6'h00);
        @(posedge clock); #1;
        reset = 0; wr_en = 0;
        step();
        rd0("async_r12", 12, 6'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
